// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared constants and round-robin pick helper for regfile_wr_arb
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int unsigned STAT_W  = 16;
  // Widest requester vector rr_pick handles; callers zero-extend into it.
  localparam int unsigned MAX_REQ = 32;

  // One-hot grant for the first set bit of valid at or after ptr, wrapping at n-1.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input int unsigned        ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin pointer and one-hot grant for N requesters
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      next_ptr;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), int'(ptr), N);
    grant = en ? pick[N-1:0] : '0;
  end

  always_comb begin
    next_ptr = ptr;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) next_ptr = (i == int'(N) - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= '0;
    else       ptr <= next_ptr;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_arb.sv
// ============================================================================
// regfile_wr_arb : round-robin write arbiter feeding one register-file write
//                  port; out-of-range addresses are dropped and flagged.
// Optional       : REGFILE_WR_ARB_STATS_EN adds grant_cnt / stall_cnt ports.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = 1,
  parameter  int unsigned N_REG = 1,
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned AW    = ($clog2(N_REG) > 0) ? $clog2(N_REG) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        freeze,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0][AW-1:0]    req_addr,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
  output logic                        wen,
  output logic [AW-1:0]               waddr,
  output logic [WIDTH-1:0]            wdata,
  output logic                        err_oob
`ifdef REGFILE_WR_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]            stall_cnt
`endif
);

  logic [N_REQ-1:0] arb_grant;
  logic             any_grant;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rstn  (rstn),
    .en    (!freeze),
    .valid (req_valid),
    .grant (arb_grant)
  );

  // The arbiter pointer is already held by reset; ready is masked so no
  // requester sees a handshake while rstn is low.
  assign req_ready = arb_grant & {N_REQ{rstn}};
  assign any_grant = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
    sel_oob = (32'(sel_addr) >= N_REG);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen     <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      err_oob <= 1'b0;
    end else begin
      wen     <= 1'b0;
      err_oob <= 1'b0;
      if (any_grant) begin
        if (sel_oob) begin
          err_oob <= 1'b1;
        end else begin
          wen   <= 1'b1;
          waddr <= sel_addr;
          wdata <= sel_data;
        end
      end
    end
  end

`ifdef REGFILE_WR_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req_ready[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
      end
      if ((|req_valid) && !any_grant && (stall_cnt != '1)) stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arb.sv
// ============================================================================
// tb_regfile_wr_arb : directed scoreboard bench for regfile_wr_arb
//                     (WIDTH=8, N_REG=6, N_REQ=4)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_arb;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_REG = 6;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned AW    = 3;

  logic                        clk;
  logic                        rstn;
  logic                        freeze;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][AW-1:0]    req_addr;
  logic [N_REQ-1:0][WIDTH-1:0] req_data;
  logic                        wen;
  logic [AW-1:0]               waddr;
  logic [WIDTH-1:0]            wdata;
  logic                        err_oob;

  logic [N_REQ-1:0][AW-1:0]    nxt_addr;
  logic [N_REQ-1:0][WIDTH-1:0] nxt_data;

  // Expected output item: {wen, err_oob, waddr, wdata}
  logic [12:0] exp_q[$];
  int          checks;
  int          errors;

  regfile_wr_arb #(
    .WIDTH (WIDTH),
    .N_REG (N_REG),
    .N_REQ (N_REQ)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .freeze    (freeze),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .err_oob   (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs applied 2 time units after an edge are consumed at the following edge.
  task automatic step(input logic [3:0] v, input logic fr, input logic [3:0] exp_ready,
                      input bit push, input bit pw, input bit pe,
                      input logic [2:0] pa, input logic [7:0] pd);
    @(posedge clk);
    #2;
    req_addr  = nxt_addr;
    req_data  = nxt_data;
    req_valid = v;
    freeze    = fr;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (push) exp_q.push_back({pw, pe, pa, pd});
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    if (rstn && (wen || err_oob)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got wen=%0b err=%0b waddr=%0h wdata=%0h, expected none",
                 wen, err_oob, waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if ({wen, err_oob, waddr, wdata} !== e) begin
          errors++;
          $display("FAIL out_stage: got wen=%0b err=%0b waddr=%0h wdata=%0h, expected wen=%0b err=%0b waddr=%0h wdata=%0h",
                   wen, err_oob, waddr, wdata, e[12], e[11], e[10:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rstn      = 1'b0;
    freeze    = 1'b0;
    req_valid = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      nxt_addr[i] = AW'(i);
      nxt_data[i] = 8'hA0 + 8'(i);
    end
    req_addr = nxt_addr;
    req_data = nxt_data;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_wen", 32'(wen), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_err", 32'(err_oob), 0);
    req_valid = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(posedge clk);
    #2;
    rstn = 1'b1;

    // All four valid: strict rotation 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++)
      step(4'hF, 1'b0, 4'(1 << (k % 4)), 1'b1, 1'b1, 1'b0, 3'(k % 4), 8'hA0 + 8'(k % 4));

    // This grant registers but is wiped by the reset that follows
    step(4'hF, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    @(posedge clk);
    #2;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'(4'b0010));
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_wen", 32'(wen), 0);
    chk("midrst_err", 32'(err_oob), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    step(4'hF, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA0);

    // Single requester 2
    nxt_addr[2] = 3'd3;
    nxt_data[2] = 8'hA5;
    step(4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 3'd3, 8'hA5);

    // Out-of-range address: flagged, waddr/wdata hold
    nxt_addr[1] = 3'd7;
    nxt_data[1] = 8'h5A;
    step(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 3'd3, 8'hA5);
    nxt_addr[1] = 3'd1;
    nxt_data[1] = 8'hA1;

    // Freeze for three cycles, then resume from the saved pointer (2)
    repeat (3) step(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA0);
    step(4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 3'd1, 8'hA1);
    step(4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA0);

    // Address boundary: N_REG-1 is written, N_REG is flagged
    nxt_addr[3] = 3'd5;
    nxt_data[3] = 8'h33;
    step(4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd5, 8'h33);
    nxt_addr[3] = 3'd6;
    nxt_data[3] = 8'h44;
    step(4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 3'd5, 8'h33);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);

    repeat (4) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("idle_wen", 32'(wen), 0);
    chk("idle_err", 32'(err_oob), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
